// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and an iterative shift-add multiply
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     acc, mcand, mplier, acc_nx, alu_res;
    logic [SHAMT_W-1:0]   cnt, shamt;
    logic                 accept, last, illegal_op;

    assign shamt      = b[SHAMT_W-1:0];
    assign in_ready   = !rst && (state == IDLE || (state == DONE && out_ready));
    assign out_valid  = state == DONE;
    assign accept     = in_valid && in_ready;
    assign last       = cnt == SHAMT_W'(WIDTH - 1);
    assign illegal_op = op > OP_MUL;
    assign acc_nx     = mplier[0] ? acc + mcand : acc;

    always_comb begin
        alu_res = '0;
        case (op)
            4'b0000: alu_res = a + b;
            4'b0001: alu_res = a - b;
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0100: alu_res = a ^ b;
            4'b0101: alu_res = a << shamt;
            4'b0110: alu_res = a >> shamt;
            4'b0111: alu_res = $signed(a) >>> shamt;
            4'b1000: alu_res = WIDTH'($signed(a) < $signed(b));
            4'b1001: alu_res = WIDTH'(a < b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = op == OP_MUL ? BUSY : DONE;
        else if (state == BUSY && last)
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (accept && op == OP_MUL) begin
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= '0;
            end else if (accept) begin
                result  <= alu_res;
                zero    <= alu_res == '0;
                illegal <= illegal_op;
            end else if (state == BUSY) begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // final iteration publishes the sum including this edge's add
                if (last) begin
                    result  <= acc_nx;
                    zero    <= acc_nx == '0;
                    illegal <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed scoreboard bench for alu_seq
module tb_alu_seq;
    localparam int W = 32;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [W-1:0]  a = '0, b = '0, result;
    logic [3:0]    op = '0;
    logic          zero, illegal;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        il;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, cyc = 0;
    bit   seen = 0, rnd = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at cycle %0d", nm, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        int unsigned s;
        longint unsigned p;
        s = y % 32;
        e.r = 0;
        e.il = 0;
        e.c = 0;
        case (o)
            0: e.r = x + y;
            1: e.r = x - y;
            2: e.r = x & y;
            3: e.r = x | y;
            4: e.r = x ^ y;
            5: e.r = x << s;
            6: e.r = x >> s;
            7: e.r = (x >> s) | (x[31] ? ~(32'hFFFFFFFF >> s) : 32'h0);
            8: e.r = ((x ^ 32'h80000000) < (y ^ 32'h80000000)) ? 1 : 0;
            9: e.r = (x < y) ? 1 : 0;
            10: begin
                p = longint'(x) * longint'(y);
                e.r = p[31:0];
            end
            default: e.il = 1;
        endcase
        e.z = e.r == 0;
        return e;
    endfunction

    // Scoreboard monitor: latency checked when an item first shows, payload on transfer
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) seen = 0;
        else begin
            if (out_valid && !seen) begin
                seen = 1;
                if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
                else chk("latency_cycle", cyc, sb[0].c);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("zero", zero, e.z);
                chk("illegal", illegal, e.il);
                seen = 0;
            end
        end
    end

    task automatic step_ready();
        if (rnd) out_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit keep);
        exp_t e;
        int   n = 0, bad = 0;
        in_valid = 1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            step_ready();
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 0;
            return;
        end
        e = model(o, x, y);
        e.c = cyc + 1 + (o == 4'b1010 ? W : 0);
        sb.push_back(e);
        @(posedge clk); #1;
        step_ready();
        if (!keep || o == 4'b1010) begin
            in_valid = 0;
            a = $urandom;
            b = $urandom;
            op = 4'($urandom);
        end
        if (o == 4'b1010) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                if (in_ready || out_valid) bad++;
                @(posedge clk); #1;
                step_ready();
            end
            chk("mul_busy_in_ready_low", bad, 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        in_valid = 0;
        while (sb.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, illegal}, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1;

        issue(4'b0000, 32'hFFFFFFFF, 32'h00000001, 0);
        issue(4'b0111, 32'h80000000, 32'h00000024, 0);
        issue(4'b0110, 32'h80000000, 32'h00000024, 0);
        issue(4'b0101, 32'h00000001, 32'h00000021, 0);
        issue(4'b1000, 32'hFFFFFFFF, 32'h00000001, 0);
        issue(4'b1001, 32'hFFFFFFFF, 32'h00000001, 0);
        issue(4'b1010, 32'd7, 32'd6, 0);
        issue(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        issue(4'b1010, 32'h00010000, 32'h00010000, 0);
        issue(4'b1100, 32'h12345678, 32'h9ABCDEF0, 0);
        drain();

        out_ready = 0;
        issue(4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_result_hold", result, 32'h0F0FF0F0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1;
        issue(4'b0000, 32'd2, 32'd3, 0);
        drain();

        in_valid = 1;
        op = 4'b1010;
        a = 32'd1234;
        b = 32'd5678;
        @(negedge clk);
        chk("rst_mul_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        repeat (9) @(posedge clk);
        #1 rst = 1;
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_mid_busy_out_valid", out_valid, 0);
        chk("rst_mid_busy_result", result, 0);
        chk("rst_mid_busy_in_ready", in_ready, 1);
        bad = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("no_stale_mul", bad, 0);
        @(posedge clk); #1;

        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 7) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            issue(o, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom,
                  $urandom_range(0, 1) == 1);
            if (!in_valid) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                step_ready();
            end
        end
        rnd = 0;
        drain();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
